mod_sample_sequencer: RTL and testbench

- Initiator side of the sine source trigger/ready handshake.
- Divides the global clock into a sample-rate tick, issues one trigger per tick with a stable 64-bit sample time, and waits for the ready pulse.
- Captures the returned signed sample into a one-entry output register and presents it downstream (DAC/mixer) over a valid/accept handshake.
- Flags overruns and missing responses.

---
 rtl/mod_sample_sequencer_if.sv | 39 +++
 rtl/mod_sample_sequencer.sv | 145 ++++++++++++++
 tb/tb_mod_sample_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_sample_sequencer_if.sv
// Sample sequencer bus: trigger/ready link to the sine source plus the
// valid/accept link to the downstream consumer (DAC/mixer).
//   i_enable  run enable
//   o_time    64-bit sample index presented with the trigger
//   o_trigger one-cycle sample request
//   i_sine    signed sample from the source, valid only with i_ready
//   i_ready   one-cycle response pulse from the source
//   o_sample  captured signed sample
//   o_valid   o_sample holds an unconsumed sample
//   i_accept  downstream consumes o_sample when o_valid & i_accept
//   o_overrun sticky overwrite flag
//   o_timeout sticky missing-response flag
//   o_state   current FSM state (debug visibility)
// Handshakes: a sample is transferred on every clock edge where
// o_valid & i_accept are both high; i_ready is a single-cycle strobe with
// no back-pressure, and o_trigger is a single-cycle strobe.
interface mod_sample_sequencer_if;
  logic        i_enable;
  logic [63:0] o_time;
  logic        o_trigger;
  logic [31:0] i_sine;
  logic        i_ready;
  logic [31:0] o_sample;
  logic        o_valid;
  logic        i_accept;
  logic        o_overrun;
  logic        o_timeout;
  logic [1:0]  o_state;

  modport master (
    input  i_enable, i_sine, i_ready, i_accept,
    output o_time, o_trigger, o_sample, o_valid, o_overrun, o_timeout, o_state
  );

  modport slave (
    output i_enable, i_sine, i_ready, i_accept,
    input  o_time, o_trigger, o_sample, o_valid, o_overrun, o_timeout, o_state
  );
endinterface

// File: rtl/mod_sample_sequencer.sv
// Sample sequencer: divides i_clk into a sample-rate tick, issues one
// trigger per tick carrying a stable 64-bit sample index, waits for the
// source's ready pulse, and holds the returned sample in a one-entry
// output register for the downstream valid/accept handshake.
//   i_clk   global clock
//   i_nrst  asynchronous active-low reset
//   bus     mod_sample_sequencer_if.master (see interface header)
module mod_sample_sequencer #(
  parameter int CLK_DIV = 1134,
  parameter int TIMEOUT = 64
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  mod_sample_sequencer_if.master        bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_TICK  = 2'd1,
    TRIGGER    = 2'd2,
    WAIT_READY = 2'd3
  } state_t;

  state_t             state_q,   state_d;
  logic [DIV_W-1:0]   div_q,     div_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  logic [63:0]        time_q,    time_d;
  logic [31:0]        sample_q,  sample_d;
  logic               valid_q,   valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic tick;
  logic capture;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      tmo_q     <= '0;
      time_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      tmo_q     <= tmo_d;
      time_q    <= time_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    tmo_d     = tmo_q;
    time_d    = time_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    tick      = (div_q == DIV_LAST);

    // Consumption first; a capture in the same cycle overrides it below.
    if (valid_q && bus.i_accept) begin
      valid_d = 1'b0;
    end

    // Divider runs only while active and restarts from 0 on every enable.
    if (state_q == IDLE || !bus.i_enable) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (!bus.i_enable && state_q != IDLE) begin
      // Abandon any pending request; o_time is deliberately not advanced.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          overrun_d = 1'b0;
          timeout_d = 1'b0;
          if (bus.i_enable) begin
            state_d = WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            state_d = TRIGGER;
          end
        end
        TRIGGER: begin
          tmo_d   = '0;
          state_d = WAIT_READY;
        end
        WAIT_READY: begin
          if (bus.i_ready) begin
            capture = 1'b1;
            time_d  = time_q + 64'd1;
            state_d = WAIT_TICK;
          end else if (tmo_q == TMO_LAST) begin
            // No zero sample is inserted; only the index moves on.
            timeout_d = 1'b1;
            time_d    = time_q + 64'd1;
            state_d   = WAIT_TICK;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      sample_d = bus.i_sine;
      valid_d  = 1'b1;
      if (valid_q && !bus.i_accept) begin
        overrun_d = 1'b1;
      end
    end
  end

  assign bus.o_time    = time_q;
  assign bus.o_trigger = (state_q == TRIGGER);
  assign bus.o_sample  = sample_q;
  assign bus.o_valid   = valid_q;
  assign bus.o_overrun = overrun_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_state   = state_q;

endmodule

// File: tb/tb_mod_sample_sequencer.sv
module tb_mod_sample_sequencer;

  localparam int CLK_DIV = 8;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mod_sample_sequencer_if ifc();

  mod_sample_sequencer #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (ifc.master)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] trig_exp_q[$];
  logic [31:0] samp_exp_q[$];
  logic [31:0] src_vals_q[$];
  int          src_delay = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the trigger cycle; bounded wait.
  task automatic wait_trig(output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ifc.o_trigger && n < 40);
    if (!ifc.o_trigger) begin
      checks++;
      errors++;
      $display("FAIL trig_wait actual=no_trigger required=trigger within 40 cycles (cycle %0d)", cyc);
    end
    t = cyc;
  endtask

  // ---------------- source model ----------------
  // Answers a trigger src_delay cycles later with the next queued value;
  // an empty queue means the source stays silent.
  initial begin
    logic [31:0] v;
    ifc.i_ready = 1'b0;
    ifc.i_sine  = '0;
    forever begin
      @(negedge clk);
      if (ifc.o_trigger && src_vals_q.size() > 0) begin
        v = src_vals_q.pop_front();
        repeat (src_delay) @(negedge clk);
        ifc.i_ready = 1'b1;
        ifc.i_sine  = v;
        @(negedge clk);
        ifc.i_ready = 1'b0;
        ifc.i_sine  = '0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [63:0] et;
    logic [31:0] es;
    forever begin
      @(negedge clk);
      #1;
      if (ifc.o_trigger) begin
        if (trig_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL trig_unexpected actual_time=%0h required=no trigger (cycle %0d)", ifc.o_time, cyc);
        end else begin
          et = trig_exp_q.pop_front();
          chk("trig_time", ifc.o_time, et);
        end
      end
      if (ifc.o_valid && ifc.i_accept) begin
        if (samp_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL samp_unexpected actual=%0h required=no sample (cycle %0d)", ifc.o_sample, cyc);
        end else begin
          es = samp_exp_q.pop_front();
          chk("samp_value", {32'd0, ifc.o_sample}, {32'd0, es});
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c, t1, t2;
    ifc.i_enable = 1'b0;
    ifc.i_accept = 1'b0;

    // Reset: outputs must be zero during async reset.
    #2 nrst = 1'b0;
    #1;
    chk("rst_time",    ifc.o_time, 64'd0);
    chk("rst_trigger", {63'd0, ifc.o_trigger}, 64'd0);
    chk("rst_valid",   {63'd0, ifc.o_valid}, 64'd0);
    chk("rst_sample",  {32'd0, ifc.o_sample}, 64'd0);
    chk("rst_flags",   {62'd0, ifc.o_overrun, ifc.o_timeout}, 64'd0);
    cycles(3);
    nrst = 1'b1;
    cycles(2);

    // Test 1: normal operation, accept tied high.
    ifc.i_accept = 1'b1;
    src_delay = 2;
    src_vals_q.push_back(32'h0000_1000); src_vals_q.push_back(32'hFFFF_F000);
    samp_exp_q.push_back(32'h0000_1000); samp_exp_q.push_back(32'hFFFF_F000);
    trig_exp_q.push_back(64'd0);         trig_exp_q.push_back(64'd1);
    ifc.i_enable = 1'b1;
    c = cyc;
    wait_trig(t1);
    chk("first_trig_latency", 64'(t1 - c), 64'd9);
    wait_trig(t2);
    chk("trig_spacing", 64'(t2 - t1), 64'd8);
    cycles(4);
    chk("t1_samples_consumed", 64'(samp_exp_q.size()), 64'd0);
    chk("t1_flags", {62'd0, ifc.o_overrun, ifc.o_timeout}, 64'd0);
    ifc.i_enable = 1'b0;
    cycles(2);

    // Test 2: source never answers.
    trig_exp_q.push_back(64'd2); trig_exp_q.push_back(64'd3);
    ifc.i_enable = 1'b1;
    wait_trig(t1);
    cycles(3);
    chk("tmo_not_early", {63'd0, ifc.o_timeout}, 64'd0);
    cycles(3);
    chk("tmo_set",       {63'd0, ifc.o_timeout}, 64'd1);
    chk("tmo_time_inc",  ifc.o_time, 64'd3);
    wait_trig(t2);
    chk("tmo_trig_spacing", 64'(t2 - t1), 64'd8);
    cycles(6);
    chk("tmo_time_inc2", ifc.o_time, 64'd4);
    chk("tmo_no_valid",  {63'd0, ifc.o_valid}, 64'd0);
    ifc.i_enable = 1'b0;
    cycles(2);
    chk("tmo_cleared_idle", {63'd0, ifc.o_timeout}, 64'd0);

    // Test 3: overrun with accept held low.
    ifc.i_accept = 1'b0;
    src_vals_q.push_back(32'd5); src_vals_q.push_back(32'd7);
    trig_exp_q.push_back(64'd4); trig_exp_q.push_back(64'd5);
    samp_exp_q.push_back(32'd7);
    ifc.i_enable = 1'b1;
    wait_trig(t1);
    wait_trig(t2);
    cycles(4);
    chk("ovr_sample",  {32'd0, ifc.o_sample}, 64'd7);
    chk("ovr_valid",   {63'd0, ifc.o_valid}, 64'd1);
    chk("ovr_flag",    {63'd0, ifc.o_overrun}, 64'd1);
    ifc.i_accept = 1'b1;
    cycles(1);
    ifc.i_accept = 1'b0;
    chk("ovr_valid_cleared", {63'd0, ifc.o_valid}, 64'd0);
    chk("ovr_flag_sticky",   {63'd0, ifc.o_overrun}, 64'd1);
    cycles(1);
    ifc.i_enable = 1'b0;
    cycles(2);
    chk("ovr_cleared_idle", {63'd0, ifc.o_overrun}, 64'd0);

    // Test 4: capture coincides with accept of the previous sample.
    src_vals_q.push_back(32'h11); src_vals_q.push_back(32'h22);
    samp_exp_q.push_back(32'h11); samp_exp_q.push_back(32'h22);
    trig_exp_q.push_back(64'd6);  trig_exp_q.push_back(64'd7);
    ifc.i_enable = 1'b1;
    wait_trig(t1);
    wait_trig(t2);
    cycles(2);
    ifc.i_accept = 1'b1;
    cycles(1);
    ifc.i_accept = 1'b0;
    chk("coinc_valid",   {63'd0, ifc.o_valid}, 64'd1);
    chk("coinc_sample",  {32'd0, ifc.o_sample}, 64'h22);
    chk("coinc_overrun", {63'd0, ifc.o_overrun}, 64'd0);
    cycles(1);
    ifc.i_accept = 1'b1;
    cycles(1);
    ifc.i_accept = 1'b0;
    chk("coinc_drained", {63'd0, ifc.o_valid}, 64'd0);
    ifc.i_enable = 1'b0;
    cycles(2);

    // Test 5: enable dropped in WAIT_READY, late ready ignored.
    src_vals_q.push_back(32'h55);
    trig_exp_q.push_back(64'd8);
    ifc.i_enable = 1'b1;
    wait_trig(t1);
    cycles(1);
    ifc.i_enable = 1'b0;
    cycles(3);
    chk("drop_no_capture", {63'd0, ifc.o_valid}, 64'd0);
    chk("drop_time_held",  ifc.o_time, 64'd8);
    chk("drop_no_flag",    {62'd0, ifc.o_overrun, ifc.o_timeout}, 64'd0);
    trig_exp_q.push_back(64'd8);
    ifc.i_enable = 1'b1;
    c = cyc;
    wait_trig(t1);
    chk("reenable_latency", 64'(t1 - c), 64'd9);
    cycles(1);
    ifc.i_enable = 1'b0;
    cycles(2);

    // Test 6: o_time wrap, then async reset mid-WAIT_READY.
    force dut.time_q = 64'hFFFF_FFFF_FFFF_FFFF;
    cycles(1);
    release dut.time_q;
    src_vals_q.push_back(32'h0BAD_F00D);
    trig_exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    trig_exp_q.push_back(64'd0);
    trig_exp_q.push_back(64'd1);
    ifc.i_enable = 1'b1;
    wait_trig(t1);
    cycles(3);
    chk("wrap_time",   ifc.o_time, 64'd0);
    chk("wrap_valid",  {63'd0, ifc.o_valid}, 64'd1);
    chk("wrap_sample", {32'd0, ifc.o_sample}, 64'h0BAD_F00D);
    wait_trig(t1);
    wait_trig(t2);
    chk("pre_rst_timeout", {63'd0, ifc.o_timeout}, 64'd1);
    cycles(1);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_time",   ifc.o_time, 64'd0);
    chk("async_rst_valid",  {63'd0, ifc.o_valid}, 64'd0);
    chk("async_rst_sample", {32'd0, ifc.o_sample}, 64'd0);
    chk("async_rst_flags",  {62'd0, ifc.o_overrun, ifc.o_timeout}, 64'd0);
    chk("async_rst_trig",   {63'd0, ifc.o_trigger}, 64'd0);
    ifc.i_enable = 1'b0;
    cycles(2);
    nrst = 1'b1;
    cycles(3);

    chk("trig_queue_drained", 64'(trig_exp_q.size()), 64'd0);
    chk("samp_queue_drained", 64'(samp_exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
